rdout_train_ctrl: RTL and testbench
===================================

Name: rdout_train_ctrl

Overview:
Sequencer directly upstream and downstream of the readout LMS trainer (rdout_top).
- Drives the 6-bit sample address and the readout ce over a programmable number of training epochs.
- Tags each returned estimate with its address.
- On completion, freezes the readout and snapshots the learned W_out bank for software/host readback.

Parameters:
ADDR_W, 6, sample address width (matches true_output_ROM address)
SEQ_LEN, 64, samples per epoch; addr wraps SEQ_LEN-1 -> 0
EPOCH_W, 8, epoch counter / num_epochs width
DRAIN_LAT, 4, cycles ce is held after last address so final update reaches W_out
EST_LAT, 3, cycles from addr presented to matching est at input
W_W, 256, weight bus width (8 x 32-bit Q-format weights)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin training run (sampled in IDLE only)
abort  in  1  terminate run, return to IDLE
num_epochs  in  EPOCH_W  epochs to run, latched on accepted start
addr  out  ADDR_W  sample address to reservoir/readout
rdout_ce  out  1  readout clock-enable
est  in  32  predicted output from readout
w_out  in  W_W  live weights from readout
est_valid  out  1  est_q/est_addr valid this cycle
est_q  out  32  registered est
est_addr  out  ADDR_W  address that produced est_q
epoch  out  EPOCH_W  current epoch index
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle completion pulse
w_final  out  W_W  weights snapshotted at completion

Behaviour:
- Reset: state IDLE; addr, epoch, rdout_ce, est_valid, est_q, est_addr, busy, done, w_final all 0; delay line cleared. Reset mid-run aborts immediately, with no done.
- All outputs are registered. Cycle n = cycle in which start is sampled high in IDLE.
- IDLE:
  - start & num_epochs!=0 -> RUN; latch num_epochs; epoch<=0.
  - start & num_epochs==0 -> DONE directly; w_final unchanged; rdout_ce never asserted.
- RUN:
  - Cycle n+1 presents addr=0, rdout_ce=1; addr increments every cycle.
  - At addr==SEQ_LEN-1: if epoch==latched-1 -> DRAIN; else addr<=0, epoch++.
  - Total RUN cycles = num_epochs*SEQ_LEN.
- DRAIN:
  - DRAIN_LAT cycles; rdout_ce stays 1; addr holds SEQ_LEN-1; no new est tags issued.
  - On the last DRAIN cycle -> DONE and w_final<=w_out.
- DONE:
  - One cycle: done=1, rdout_ce=0, busy=0; w_final stable.
  - -> IDLE. w_final holds until the next DONE.
- abort (RUN/DRAIN): next cycle IDLE, rdout_ce=0, busy=0, no done, w_final unchanged. abort in IDLE/DONE is ignored. abort has priority over any same-cycle wrap/transition.
- start while not IDLE is ignored. start and abort together in IDLE: start wins.
- Est tagging:
  - Each RUN cycle pushes {1, addr} into an EST_LAT-deep shift register; all other states push {0, x}.
  - Output stage registers est_valid=tag_valid, est_addr=tag_addr, est_q=est. This gives est_valid EST_LAT+1 cycles after the addr cycle.
  - abort/reset flushes the delay line, so no est_valid follows an abort.
- epoch output reflects the epoch of the current addr. It is held after DONE until the next start.

Decomposition:
- Package rdout_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - ADDR_W/EPOCH_W/W_W constants
  - est/weight width localparams
- Sub-module rdout_tag_delay: parameterised depth/width valid+data shift register with synchronous flush. It is reusable for aligning reservoir state.

Test Plan:
1. num_epochs=1, start at cycle 0 -> addr 0..63 on cycles 1..64 with rdout_ce=1; DRAIN cycles 65..68; done=1 at cycle 69; w_final equals w_out sampled at cycle 68; rdout_ce=0 from 69.
2. num_epochs=3 -> epoch 0/1/2 changes at cycles 65 and 129; addr wraps 63->0 twice; done at cycle 1+192+4=197; exactly 192 est_valid pulses.
3. Est alignment, EST_LAT=3, est driven = addr value -> first est_valid at cycle 5 with est_addr=0, est_q=0; est_addr always equals est_q[5:0].
4. abort at cycle 30 (addr=29) -> cycle 31 IDLE, rdout_ce=0, busy=0; no done ever; w_final keeps prior value; no est_valid after cycle 31.
5. num_epochs=0 start -> done at cycle 1, rdout_ce never 1, w_final unchanged; start pulsed at cycle 10 of a running job -> ignored, done timing unchanged.
6. rst asserted at cycle 40 of a run -> cycle 41 all outputs 0, state IDLE; a new start then produces a normal run identical to scenario 1.

Source files
------------

// File: rtl/rdout_pkg.sv
// Shared types and sizing for the readout training sequencer.
package rdout_pkg;

    localparam int ADDR_W    = 6;
    localparam int SEQ_LEN   = 64;
    localparam int EPOCH_W   = 8;
    localparam int DRAIN_LAT = 4;
    localparam int EST_LAT   = 3;
    localparam int W_W       = 256;
    localparam int EST_W     = 32;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SEQ_LEN - 1);
    localparam int DRAIN_W = $clog2(DRAIN_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rdout_train_ctrl_if.sv
// Control, sample-address, estimate and weight signals between host, readout and sequencer.
interface rdout_train_ctrl_if;
    import rdout_pkg::*;

    logic               start;
    logic               abort;
    logic [EPOCH_W-1:0] num_epochs;
    logic [ADDR_W-1:0]  addr;
    logic               rdout_ce;
    logic [EST_W-1:0]   est;
    logic [W_W-1:0]     w_out;
    logic               est_valid;
    logic [EST_W-1:0]   est_q;
    logic [ADDR_W-1:0]  est_addr;
    logic [EPOCH_W-1:0] epoch;
    logic               busy;
    logic               done;
    logic [W_W-1:0]     w_final;

    modport slave (
        input  start, abort, num_epochs, est, w_out,
        output addr, rdout_ce, est_valid, est_q, est_addr, epoch, busy, done, w_final
    );

    modport master (
        output start, abort, num_epochs, est, w_out,
        input  addr, rdout_ce, est_valid, est_q, est_addr, epoch, busy, done, w_final
    );

endinterface

// File: rtl/rdout_tag_delay.sv
// Valid+data shift register of configurable depth with synchronous flush.
module rdout_tag_delay #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             vld [DEPTH];
    logic [WIDTH-1:0] dat [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld[i] <= 1'b0;
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            dat[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/rdout_train_ctrl.sv
// Sequences readout LMS training epochs, tags returned estimates, snapshots learned weights.
//  state | meaning
//  IDLE  | waiting for start; outputs held
//  RUN   | sweeping addr 0..SEQ_LEN-1 once per epoch with rdout_ce high
//  DRAIN | addr parked at last sample, ce held so the final update lands
//  DONE  | one-cycle done pulse, w_final captured
module rdout_train_ctrl
    import rdout_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    rdout_train_ctrl_if.slave bus
);

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic [EPOCH_W-1:0] epoch;
    logic [EPOCH_W-1:0] epochs_lat;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               rdout_ce;
    logic               busy;
    logic               done;
    logic [W_W-1:0]     w_final;

    logic               est_valid;
    logic [EST_W-1:0]   est_q;
    logic [ADDR_W-1:0]  est_addr;

    logic               flush;
    logic               tag_valid;
    logic [ADDR_W-1:0]  tag_addr;

    assign flush = bus.abort && (state == RUN || state == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            epoch      <= '0;
            epochs_lat <= '0;
            drain_cnt  <= '0;
            rdout_ce   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            w_final    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        epoch <= '0;
                        if (bus.num_epochs != '0) begin
                            state      <= RUN;
                            epochs_lat <= bus.num_epochs;
                            addr       <= '0;
                            rdout_ce   <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state    <= IDLE;
                        rdout_ce <= 1'b0;
                        busy     <= 1'b0;
                    end else if (addr == LAST_ADDR) begin
                        if (epoch == epochs_lat - EPOCH_W'(1)) begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_W'(DRAIN_LAT - 1);
                        end else begin
                            addr  <= '0;
                            epoch <= epoch + EPOCH_W'(1);
                        end
                    end else begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (bus.abort) begin
                        state    <= IDLE;
                        rdout_ce <= 1'b0;
                        busy     <= 1'b0;
                    end else if (drain_cnt == '0) begin
                        state    <= DONE;
                        rdout_ce <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        w_final  <= bus.w_out;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    rdout_ce <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Only RUN cycles issue tags; the readout answers EST_LAT cycles later.
    rdout_tag_delay #(
        .DEPTH (EST_LAT),
        .WIDTH (ADDR_W)
    ) u_tag_delay (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (state == RUN),
        .in_data   (addr),
        .out_valid (tag_valid),
        .out_data  (tag_addr)
    );

    // Gating on flush keeps a tag already leaving the line from surfacing after abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            est_valid <= 1'b0;
            est_q     <= '0;
            est_addr  <= '0;
        end else begin
            est_valid <= tag_valid && !flush;
            est_addr  <= tag_addr;
            est_q     <= bus.est;
        end
    end

    assign bus.addr      = addr;
    assign bus.rdout_ce  = rdout_ce;
    assign bus.epoch     = epoch;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.w_final   = w_final;
    assign bus.est_valid = est_valid;
    assign bus.est_q     = est_q;
    assign bus.est_addr  = est_addr;

endmodule

// File: tb/tb_rdout_train_ctrl.sv
// Directed bench for rdout_train_ctrl against a timeline model of training runs.
module tb_rdout_train_ctrl;
    import rdout_pkg::*;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   vcnt;

    rdout_train_ctrl_if bus ();

    rdout_train_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W_W-1:0] wpat(input int c);
        logic [W_W-1:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = 32'(c) * 32'd9 + 32'(i) * 32'h0101_0000 + 32'hA500_0000;
        return w;
    endfunction

    // Readout stand-in: est returns the address presented EST_LAT cycles earlier.
    logic [ADDR_W-1:0] a1, a2, a3;
    always @(posedge clk) begin
        a1 <= bus.addr;
        a2 <= a1;
        a3 <= a2;
    end
    assign bus.est   = {26'd0, a3};
    assign bus.w_out = wpat(cyc);

    task automatic chk(input string name, input logic [W_W-1:0] act, input logic [W_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: a run is described by its first RUN cycle and epoch count.
    bit             rv;
    int             mf;
    int             mn;
    int             hold_ep;
    logic [W_W-1:0] exp_w;

    initial begin
        rv = 0; mf = 0; mn = 0; hold_ep = 0; exp_w = '0; vcnt = 0;
    end

    always @(negedge clk) begin
        int k, len, e_addr, e_ep, e_eaddr;
        bit e_busy, e_done, e_ev;
        len    = mn * SEQ_LEN;
        k      = cyc - mf;
        e_busy = rv && mn != 0 && k >= 0 && k < len + DRAIN_LAT;
        e_done = rv && ((mn == 0 && k == 0) || (mn != 0 && k == len + DRAIN_LAT));
        e_ep   = !rv ? hold_ep : (mn == 0 ? 0 : (k < len ? k / SEQ_LEN : mn - 1));
        e_addr = (k < len) ? k % SEQ_LEN : SEQ_LEN - 1;
        e_ev   = rv && mn != 0 && (k - EST_LAT - 1) >= 0 && (k - EST_LAT - 1) < len;
        e_eaddr = (k - EST_LAT - 1) % SEQ_LEN;
        if (e_done && mn != 0) exp_w = wpat(cyc - 1);
        if (cyc >= 1) begin
            if (bus.est_valid === 1'b1) vcnt++;
            chk("rdout_ce", W_W'(bus.rdout_ce), W_W'(e_busy));
            chk("busy", W_W'(bus.busy), W_W'(e_busy));
            chk("done", W_W'(bus.done), W_W'(e_done));
            chk("est_valid", W_W'(bus.est_valid), W_W'(e_ev));
            chk("epoch", W_W'(bus.epoch), W_W'(e_ep));
            chk("w_final", bus.w_final, exp_w);
            if (e_busy) chk("addr", W_W'(bus.addr), W_W'(e_addr));
            if (e_ev) begin
                chk("est_addr", W_W'(bus.est_addr), W_W'(e_eaddr));
                chk("est_q", W_W'(bus.est_q), W_W'(e_eaddr));
            end
        end
        if (rst) begin
            rv = 0; hold_ep = 0; exp_w = '0;
        end else if (bus.abort && e_busy) begin
            rv = 0; hold_ep = e_ep;
        end else if (bus.start && !e_busy && !e_done) begin
            rv = 1; mf = cyc + 1; mn = int'(bus.num_epochs);
        end
    end

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample_at(input int t);
        goto(t);
        @(negedge clk);
    endtask

    task automatic pulse_start(input int t, input int n);
        goto(t);
        bus.start = 1'b1;
        bus.num_epochs = EPOCH_W'(n);
        goto(t + 1);
        bus.start = 1'b0;
    endtask

    initial begin
        int base;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.num_epochs = '0;
        goto(3);
        rst = 1'b0;
        sample_at(3);
        chk("rst_addr", W_W'(bus.addr), 0);
        chk("rst_wfinal", bus.w_final, 0);

        // One epoch starting at cycle 10.
        base = vcnt;
        pulse_start(10, 1);
        sample_at(11);
        chk("s1_addr0", W_W'(bus.addr), 0);
        chk("s1_ce", W_W'(bus.rdout_ce), 1);
        sample_at(14);
        chk("s1_ev_early", W_W'(bus.est_valid), 0);
        sample_at(15);
        chk("s1_ev_first", W_W'(bus.est_valid), 1);
        chk("s1_eaddr_first", W_W'(bus.est_addr), 0);
        sample_at(74);
        chk("s1_addr63", W_W'(bus.addr), 63);
        sample_at(78);
        chk("s1_drain_ce", W_W'(bus.rdout_ce), 1);
        chk("s1_drain_addr", W_W'(bus.addr), 63);
        sample_at(79);
        chk("s1_done", W_W'(bus.done), 1);
        chk("s1_done_ce", W_W'(bus.rdout_ce), 0);
        chk("s1_wfinal", bus.w_final, wpat(78));
        sample_at(80);
        chk("s1_pulses", W_W'(vcnt - base), 64);

        // Three epochs with a stray start mid-run.
        base = vcnt;
        pulse_start(100, 3);
        pulse_start(110, 5);
        sample_at(164);
        chk("s2_ep0", W_W'(bus.epoch), 0);
        sample_at(165);
        chk("s2_ep1", W_W'(bus.epoch), 1);
        chk("s2_wrap1", W_W'(bus.addr), 0);
        sample_at(229);
        chk("s2_ep2", W_W'(bus.epoch), 2);
        sample_at(296);
        chk("s2_not_done", W_W'(bus.done), 0);
        sample_at(297);
        chk("s2_done", W_W'(bus.done), 1);
        chk("s2_pulses", W_W'(vcnt - base), 192);

        // Abort at addr 29.
        pulse_start(320, 2);
        goto(350);
        bus.abort = 1'b1;
        goto(351);
        bus.abort = 1'b0;
        base = vcnt;
        @(negedge clk);
        chk("s4_busy", W_W'(bus.busy), 0);
        chk("s4_ce", W_W'(bus.rdout_ce), 0);
        chk("s4_wfinal", bus.w_final, wpat(296));
        sample_at(410);
        chk("s4_no_ev", W_W'(vcnt - base), 0);

        // Zero epochs, idle abort, then start+abort together.
        pulse_start(420, 0);
        sample_at(421);
        chk("s5_done", W_W'(bus.done), 1);
        chk("s5_wfinal", bus.w_final, wpat(296));
        goto(430);
        bus.abort = 1'b1;
        goto(431);
        bus.abort = 1'b0;
        goto(440);
        bus.abort = 1'b1;
        pulse_start(440, 1);
        bus.abort = 1'b0;
        sample_at(509);
        chk("s5_sa_done", W_W'(bus.done), 1);

        // Reset mid-run, then a clean run.
        pulse_start(520, 1);
        goto(560);
        rst = 1'b1;
        goto(561);
        rst = 1'b0;
        @(negedge clk);
        chk("s6_busy", W_W'(bus.busy), 0);
        chk("s6_addr", W_W'(bus.addr), 0);
        chk("s6_wfinal", bus.w_final, 0);
        pulse_start(570, 1);
        sample_at(575);
        chk("s6_ev_first", W_W'(bus.est_valid), 1);
        sample_at(639);
        chk("s6_done", W_W'(bus.done), 1);
        chk("s6_wfinal2", bus.w_final, wpat(638));
        sample_at(660);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout cycle %0d got running expected finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
